fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Pipeline control block for the five-stage RISC-V core (IF, ID, EX, MEM, WB). It generates the select lines for the two EX-stage operand 3:1 muxes and the stall/flush controls for load-use and taken-branch hazards. It keeps its own shadow pipeline of destination-register state, so it is the producer side of the operand-select interface. Forward selects are registered and valid for the instruction in EX. Stall and flush outputs are combinational.

## Interface
Parameters:
- REG_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs1, id_rs2  input  REG_W  ID source registers.
- id_use_rs1, id_use_rs2  input  1  ID instruction reads rs1/rs2.
- id_rd  input  REG_W  ID destination register.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- ex_branch_taken  input  1  EX resolved a taken branch or jump this cycle.
- forward_a, forward_b  output  2  EX operand mux selects: 00 regfile, 01 WB result, 10 MEM ALU result, 11 never driven.
- stall_if, stall_id  output  1  hold PC and the IF/ID register.
- flush_id  output  1  clear the IF/ID register.
- bubble_ex  output  1  load a NOP into ID/EX.

## Operation
- Shadow state per stage: ex_{rd,we,mr,valid}, mem_{rd,we,valid}, wb_{rd,we,valid}. The we bit is always stored ANDed with valid.
- Every clock: wb <= mem, mem <= ex. ex <= ID fields, or a bubble (all zero) when bubble_ex=1 or id_valid=0.
- Load-use detect: lu = ex_valid & ex_mr & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Combinational outputs:
  - flush_id = ex_branch_taken.
  - bubble_ex = ex_branch_taken | lu.
  - stall_if = stall_id = lu & ~ex_branch_taken. A taken branch overrides stall.
- Registered forward computation for rs1 (rs2 is identical), evaluated against the pre-edge ex/mem state:
  - If bubble or id_use_rs1=0: 00.
  - Else if ex_we & ex_rd != 0 & ex_rd == id_rs1 & ~ex_mr: 10.
  - Else if mem_we & mem_rd != 0 & mem_rd == id_rs1: 01.
  - Else 00.
  - The nearer stage wins when both match.
- Loaded data always arrives through 01. The one-cycle stall places the load in WB when the consumer reaches EX.
- x0 is never forwarded and never causes a stall.
- The register file is write-first, so a WB-to-ID collision needs no handling here.

## Timing
- Reset (rst=1 at an edge):
  - All shadow valid/we/mr bits clear; forward_a = forward_b = 00.
  - While rst=1, stall_if, stall_id, flush_id and bubble_ex are forced to 0.
- Forward latency: computed at the ID->EX edge and held constant for the whole EX cycle.
- Load-use:
  - Stall lasts exactly one cycle; on the next cycle the load is in MEM, so lu=0.
  - The stalled instruction re-presents in ID, and its recompute yields 01.
- Taken branch: flush_id and bubble_ex assert in the same cycle as ex_branch_taken. After the edge, ex holds a bubble and the stall from that cycle is dropped.
- Back-to-back stalls occur only for consecutive dependent loads; each stall is one cycle.
- Reset mid-stall: the stall clears at the reset edge. No shadow entry survives.

## Test plan
- Reset with ex_branch_taken=1 -> all outputs 0. After release, forward_a/forward_b stay 00 until the first valid dependent instruction.
- add x5 (ID) followed by sub using rs1=x5 -> the cycle sub is in EX: forward_a=10, forward_b=00, no stall.
- add x5; nop; or rs2=x5 -> or in EX: forward_b=01. With add x5 then add x5 then use x5 -> 10 (nearest wins).
- lw x7 in EX, ID uses rs2=x7 -> stall_if=stall_id=bubble_ex=1 for one cycle. Next EX cycle of the consumer: forward_b=01.
- lw x7 in EX with a dependent in ID plus ex_branch_taken=1 -> flush_id=1, bubble_ex=1, stall_if=0.
- Writes to x0 followed by reads of x0 -> forward 00 and no stall. Asserting rst during the load-use stall cycle -> the stall drops at the edge.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding selects plus load-use / taken-branch hazard control
// Keeps a shadow of destination-register state for the instructions in EX and MEM.
module fwd_hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex
);

  // WB needs no shadow: the write-first register file already covers that distance.
  logic             ex_valid, ex_we, ex_mr;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid, mem_we;
  logic [REG_W-1:0] mem_rd;

  logic       lu;
  logic       insert_bubble;
  logic       ex_fwd_ok, mem_fwd_ok;
  logic [1:0] fa_next, fb_next;

  always_comb begin
    lu = ex_valid & ex_mr & (ex_rd != '0) & id_valid &
         ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  assign flush_id  = ~rst & ex_branch_taken;
  assign bubble_ex = ~rst & (ex_branch_taken | lu);
  assign stall_if  = ~rst & lu & ~ex_branch_taken;
  assign stall_id  = stall_if;

  assign insert_bubble = ex_branch_taken | lu | ~id_valid;

  // A load in EX cannot supply its data yet; its consumer is caught by the load-use stall.
  assign ex_fwd_ok  = ex_valid & ex_we & ~ex_mr & (ex_rd != '0);
  assign mem_fwd_ok = mem_valid & mem_we & (mem_rd != '0);

  always_comb begin
    fa_next = 2'b00;
    fb_next = 2'b00;
    if (!insert_bubble) begin
      if (id_use_rs1) begin
        if (ex_fwd_ok && (ex_rd == id_rs1))        fa_next = 2'b10;
        else if (mem_fwd_ok && (mem_rd == id_rs1)) fa_next = 2'b01;
      end
      if (id_use_rs2) begin
        if (ex_fwd_ok && (ex_rd == id_rs2))        fb_next = 2'b10;
        else if (mem_fwd_ok && (mem_rd == id_rs2)) fb_next = 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_we     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_rd    <= '0;
      forward_a <= 2'b00;
      forward_b <= 2'b00;
    end else begin
      mem_valid <= ex_valid;
      mem_we    <= ex_we;
      mem_rd    <= ex_rd;
      if (insert_bubble) begin
        ex_valid <= 1'b0;
        ex_we    <= 1'b0;
        ex_mr    <= 1'b0;
        ex_rd    <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_we    <= id_reg_write;
        ex_mr    <= id_mem_read;
        ex_rd    <= id_rd;
      end
      forward_a <= fa_next;
      forward_b <= fb_next;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed and randomized checks of fwd_hazard_unit against an in-flight instruction model
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] forward_a, forward_b;
  logic       stall_if, stall_id, flush_id, bubble_ex;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .bubble_ex(bubble_ex)
  );

  // Instructions that entered EX, youngest first; slot 0 is in EX, slot 1 in MEM.
  typedef struct {bit writes; bit load; int rd;} instr_t;
  instr_t inflight[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit last_stall = 0;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Closest older writer of rs: one instruction ahead comes from MEM (10), two ahead from WB (01).
  function automatic logic [1:0] nearest(input int rs);
    for (int d = 0; d < 2 && d < inflight.size(); d++)
      if (inflight[d].writes && inflight[d].rd == rs && rs != 0)
        return (d == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    bit lu_m, e_stall, e_flush, e_bub;
    logic [1:0] efa, efb;
    instr_t e;
    @(negedge clk);
    lu_m = 0;
    if (inflight.size() > 0 && inflight[0].load && inflight[0].rd != 0 && id_valid &&
        ((id_use_rs1 && id_rs1 == inflight[0].rd) || (id_use_rs2 && id_rs2 == inflight[0].rd)))
      lu_m = 1;
    e_flush = !rst && ex_branch_taken;
    e_bub   = !rst && (ex_branch_taken || lu_m);
    e_stall = !rst && lu_m && !ex_branch_taken;
    check("stall_if", stall_if, e_stall);
    check("stall_id", stall_id, e_stall);
    check("flush_id", flush_id, e_flush);
    check("bubble_ex", bubble_ex, e_bub);
    efa = (rst || ex_branch_taken || lu_m || !id_valid || !id_use_rs1) ? 2'b00 : nearest(id_rs1);
    efb = (rst || ex_branch_taken || lu_m || !id_valid || !id_use_rs2) ? 2'b00 : nearest(id_rs2);
    @(posedge clk);
    if (rst) begin
      inflight.delete();
    end else begin
      e = '{0, 0, 0};
      if (id_valid && !ex_branch_taken && !lu_m) e = '{id_reg_write, id_mem_read, id_rd};
      inflight.push_front(e);
      if (inflight.size() > 2) void'(inflight.pop_back());
    end
    #1;
    check("forward_a", forward_a, efa);
    check("forward_b", forward_b, efb);
    last_stall = e_stall;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit we, input bit mr);
    id_valid = v; id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
    id_rd = 5'(rd); id_reg_write = we; id_mem_read = mr;
  endtask

  initial begin
    rst = 1; ex_branch_taken = 1;
    set_id(1, 3, 1, 3, 1, 3, 1, 1);
    tick(); tick();
    rst = 0; ex_branch_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    // add x5 ; sub x6, x5, x6
    set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
    set_id(1, 5, 1, 6, 1, 6, 1, 0); tick();
    // add x5 ; nop ; or rs2=x5
    set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 4, 1, 5, 1, 8, 1, 0); tick();
    // add x5 ; add x5 ; use x5
    set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
    set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
    set_id(1, 5, 1, 0, 0, 9, 1, 0); tick();
    // lw x7 ; consumer of x7 on rs2 stalls once then takes 01
    set_id(1, 1, 1, 0, 0, 7, 1, 1); tick();
    set_id(1, 3, 1, 7, 1, 10, 1, 0); tick(); tick();
    // lw x7 with dependent in ID and a taken branch
    set_id(1, 1, 1, 0, 0, 7, 1, 1); tick();
    set_id(1, 3, 1, 7, 1, 10, 1, 0); ex_branch_taken = 1; tick();
    ex_branch_taken = 0;
    // x0 writes and loads never forward or stall
    set_id(1, 1, 1, 0, 0, 0, 1, 0); tick();
    set_id(1, 0, 1, 0, 1, 4, 1, 0); tick();
    set_id(1, 1, 1, 0, 0, 0, 1, 1); tick();
    set_id(1, 0, 1, 0, 1, 4, 1, 0); tick();
    // reset during the load-use stall cycle
    set_id(1, 1, 1, 0, 0, 9, 1, 1); tick();
    set_id(1, 9, 1, 2, 1, 11, 1, 0); rst = 1; tick();
    rst = 0; tick();

    for (int i = 0; i < 600; i++) begin
      if (!last_stall)
        set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
